axis_rx_frame_checker: RTL
==========================

Name: axis_rx_frame_checker

Overview:
Consumes the 64-bit AXI4-Stream receive path from the Ethernet wrapper (loopback test) and checks every frame against the test transmit pattern. Reports good, bad and sequence-gap frames through saturating counters and a sticky error flag, which the VIO and config logic read. Drives rx_axis_tready and never stalls the MAC unless the throttle feature is compiled in.

Parameters:
AXIS_DATA_WIDTH, 64, stream data width; only 64 is supported; tkeep is AXIS_DATA_WIDTH/8.
CNT_WIDTH, 32, width of each statistics counter.
MIN_BEATS, 8, minimum legal beats per frame, header included.
MAX_BEATS, 190, maximum legal beats per frame (1518 B / 8, rounded up).
HDR_MAGIC, 32'hA5A5_5A5A, constant in header beat bits [63:32].

Ports:
clk  in  1  stream clock (coreclk domain).
rst  in  1  asynchronous active-high reset.
chk_en  in  1  checking enable, level.
chk_clr  in  1  synchronous clear of counters, sticky flag and sequence sync, pulse.
rx_axis_tdata  in  64  receive data.
rx_axis_tkeep  in  8  byte enables; bit i qualifies byte i.
rx_axis_tvalid  in  1  receive valid.
rx_axis_tlast  in  1  last beat of frame.
rx_axis_tready  out  1  checker ready.
good_frame_cnt  out  CNT_WIDTH  frames that passed all checks.
bad_frame_cnt  out  CNT_WIDTH  frames with a data, keep or length error.
seq_err_cnt  out  CNT_WIDTH  frames whose sequence number did not match the expected value.
err_sticky  out  1  set by any error; cleared only by rst or chk_clr.
chk_busy  out  1  high while a frame is in progress (state is not WAIT_SOF).

Behaviour:
- Reset (async assert, sync release): all counters 0, err_sticky 0, rx_axis_tready 0, state WAIT_SOF, seq_valid 0, expected_seq 0. rx_axis_tready goes 1 on the first clk edge after rst falls.
- A beat is accepted when tvalid & tready. Nothing advances otherwise.
- Frame format: beat 0 is the header, {HDR_MAGIC, seq[31:0]}. Beat k (k>=1) carries {seq[31:0], k[31:0]}.
- On the last beat, only bytes with tkeep=1 are compared. tkeep must be contiguous from bit 0 and non-zero.
- On every non-last beat, tkeep must be 8'hFF; otherwise it is a keep error.
- State WAIT_SOF:
  - Accepted beat with chk_en=0: go to DROP (or stay if tlast).
  - Accepted beat with chk_en=1: check the magic and latch seq.
  - Then go to PAYLOAD; if tlast is set, this is a 1-beat frame and is treated as a length error.
- State PAYLOAD: beat index counts from 1.
  - Compare each beat.
  - Beat index reaching MAX_BEATS without tlast: length error, go to DROP.
  - tlast: finish the frame, go to WAIT_SOF.
- State DROP: accept beats without checking until tlast, then go to WAIT_SOF. Frames dropped because chk_en=0 are not counted.
- Frame finish, registered; counters are visible 1 cycle after the tlast beat is accepted:
  - Any error in the frame: bad_frame_cnt++ and err_sticky=1. Otherwise good_frame_cnt++.
  - A frame shorter than MIN_BEATS is an error.
  - Sequence check:
    - seq_valid=0: sync, no check.
    - seq_valid=1 and seq != expected_seq: seq_err_cnt++ and err_sticky=1. Resync regardless.
    - expected_seq = seq+1, wrapping at 2^32. seq_valid=1.
  - The sequence check applies to frames with a readable header, including bad-length frames.
- Length-error frame sent to DROP: counted as bad once, at its tlast.
- All counters saturate at all-ones.
- chk_en falling mid-frame: the current frame finishes and is checked normally.
- chk_en rising mid-frame: no effect until the next SOF.
- chk_clr:
  - Zeroes the counters, err_sticky and seq_valid in the same cycle.
  - Takes priority over a simultaneous frame-finish update; that frame's result is lost.
  - Does not change the state.

Optional Feature:
AXIS_RX_THROTTLE_EN
- Defined: tready is gated by bit 0 of a 16-bit maximal-length LFSR (seed 16'hACE1, advanced every cycle). The MAC-side FIFO absorbs the resulting backpressure.
- Undefined: tready is 1 whenever not in reset, and there is no LFSR logic.

Decomposition:
- Package axis_chk_pkg:
  - state enum {WAIT_SOF, PAYLOAD, DROP}.
  - HDR_MAGIC default.
  - Beat-count width: $clog2(MAX_BEATS+1).
  - Function computing the expected beat word from seq and k.
- Sub-module axis_chk_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11) with clk, rst and en. Instantiated only under AXIS_RX_THROTTLE_EN.

Test Plan:
1. chk_en=1; send 3 frames of 10 beats, seq 0,1,2, last tkeep=8'h0F → good_frame_cnt=3, bad=0, seq_err=0, err_sticky=0.
2. Frame seq 5 follows seq 2 → seq_err_cnt=1, err_sticky=1, good_frame_cnt increments. Next frame seq 6 → no further seq_err.
3. Corrupt beat 4 data by one bit; also a frame with non-last tkeep=8'h7F → bad_frame_cnt=2.
4. Length cases:
   - 5-beat frame → bad+1.
   - 200-beat frame → bad+1, exactly once; the remaining beats are dropped.
   - chk_busy returns low after tlast.
5. chk_en=0 during 2 frames → counters unchanged, tready=1. chk_clr pulsed on the same cycle as a frame's tlast → all counters 0.
6. Assert rst mid-frame → tready=0 and counters 0 immediately. After release, the next full frame is counted good with no seq error.

Source files
------------

// File: rtl/axis_chk_pkg.sv
// axis_chk_pkg: shared types, constants and helpers for the AXI4-Stream receive frame checker.
package axis_chk_pkg;
    typedef enum logic [1:0] {WAIT_SOF, PAYLOAD, DROP} state_e;
    localparam logic [31:0] DEF_HDR_MAGIC = 32'hA5A5_5A5A;
    localparam int DEF_MAX_BEATS = 190;
    function automatic int beat_w(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction
    localparam int BEAT_W = beat_w(DEF_MAX_BEATS);
    // Payload beat k of frame seq carries {seq, k}.
    function automatic logic [63:0] beat_word(input logic [31:0] seq, input logic [31:0] k);
        return {seq, k};
    endfunction
    function automatic logic [63:0] keep_mask(input logic [7:0] keep);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{keep[i]}};
        return m;
    endfunction
endpackage

// File: rtl/axis_chk_lfsr.sv
// axis_chk_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1) used to throttle tready.
module axis_chk_lfsr (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic lfsr_bit
);
    logic [15:0] lfsr_q, lfsr_d;
    always_comb lfsr_d = en ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) lfsr_q <= 16'hACE1;
        else lfsr_q <= lfsr_d;
    assign lfsr_bit = lfsr_q[0];
endmodule

// File: rtl/axis_rx_frame_checker.sv
// axis_rx_frame_checker: checks looped-back test frames and keeps saturating good/bad/sequence-gap statistics.
// Define AXIS_RX_THROTTLE_EN to gate tready with a pseudo-random LFSR bit.
module axis_rx_frame_checker
    import axis_chk_pkg::*;
#(
    parameter int          AXIS_DATA_WIDTH = 64,
    parameter int          CNT_WIDTH       = 32,
    parameter int          MIN_BEATS       = 8,
    parameter int          MAX_BEATS       = 190,
    parameter logic [31:0] HDR_MAGIC       = DEF_HDR_MAGIC
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         chk_en,
    input  logic                         chk_clr,
    input  logic [AXIS_DATA_WIDTH-1:0]   rx_axis_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0] rx_axis_tkeep,
    input  logic                         rx_axis_tvalid,
    input  logic                         rx_axis_tlast,
    output logic                         rx_axis_tready,
    output logic [CNT_WIDTH-1:0]         good_frame_cnt,
    output logic [CNT_WIDTH-1:0]         bad_frame_cnt,
    output logic [CNT_WIDTH-1:0]         seq_err_cnt,
    output logic                         err_sticky,
    output logic                         chk_busy
);
    localparam int BW = beat_w(MAX_BEATS);
    state_e               state_q, state_d;
    logic [BW-1:0]        beat_q, beat_d;
    logic                 err_q, err_d;
    logic                 hdr_ok_q, hdr_ok_d;
    logic                 chk_q, chk_d;
    logic [31:0]          seq_q, seq_d;
    logic [31:0]          exp_seq_q, exp_seq_d;
    logic                 seq_valid_q, seq_valid_d;
    logic [CNT_WIDTH-1:0] good_q, good_d, bad_q, bad_d, seqe_q, seqe_d;
    logic                 sticky_q, sticky_d;
    logic                 rdy_q, rdy_d;
    logic                 acc, last_keep_ok, keep_err, data_err, magic_ok, short_frame;
    logic                 fin, fin_err, fin_hdr, seq_mis;
    logic [31:0]          fin_seq;
    logic [63:0]          mask;
`ifdef AXIS_RX_THROTTLE_EN
    logic lfsr_bit;
    axis_chk_lfsr u_lfsr (.clk(clk), .rst(rst), .en(1'b1), .lfsr_bit(lfsr_bit));
    assign rx_axis_tready = rdy_q & lfsr_bit;
`else
    assign rx_axis_tready = rdy_q;
`endif
    // Beat qualification: only kept bytes of the last beat are compared.
    always_comb begin
        acc          = rx_axis_tvalid & rx_axis_tready;
        mask         = keep_mask(rx_axis_tlast ? rx_axis_tkeep : 8'hFF);
        last_keep_ok = (rx_axis_tkeep != 8'h00) && ((rx_axis_tkeep & (rx_axis_tkeep + 8'h01)) == 8'h00);
        keep_err     = rx_axis_tlast ? !last_keep_ok : (rx_axis_tkeep != 8'hFF);
        data_err     = |((rx_axis_tdata ^ beat_word(seq_q, 32'(beat_q))) & mask);
        magic_ok     = rx_axis_tdata[63:32] == HDR_MAGIC;
        short_frame  = beat_q < BW'(MIN_BEATS - 1);
    end
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        err_d    = err_q;
        hdr_ok_d = hdr_ok_q;
        chk_d    = chk_q;
        seq_d    = seq_q;
        fin      = 1'b0;
        fin_err  = 1'b0;
        fin_hdr  = hdr_ok_q;
        fin_seq  = seq_q;
        if (acc) begin
            case (state_q)
                WAIT_SOF: begin
                    chk_d = chk_en;
                    if (!chk_en) begin
                        state_d = rx_axis_tlast ? WAIT_SOF : DROP;
                    end else begin
                        seq_d    = rx_axis_tdata[31:0];
                        hdr_ok_d = magic_ok;
                        err_d    = keep_err | !magic_ok;
                        beat_d   = BW'(1);
                        // A header-only frame is finished here with a length error.
                        fin      = rx_axis_tlast;
                        fin_err  = 1'b1;
                        fin_hdr  = magic_ok;
                        fin_seq  = rx_axis_tdata[31:0];
                        state_d  = rx_axis_tlast ? WAIT_SOF : PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    err_d  = err_q | data_err | keep_err;
                    beat_d = beat_q + BW'(1);
                    if (rx_axis_tlast) begin
                        fin     = 1'b1;
                        fin_err = err_q | data_err | keep_err | short_frame;
                        state_d = WAIT_SOF;
                    end else if (beat_q == BW'(MAX_BEATS - 1)) begin
                        err_d   = 1'b1;
                        state_d = DROP;
                    end
                end
                default: begin
                    fin     = rx_axis_tlast & chk_q;
                    fin_err = 1'b1;
                    state_d = rx_axis_tlast ? WAIT_SOF : DROP;
                end
            endcase
        end
    end
    // Statistics; a clear wins over a frame finishing in the same cycle.
    always_comb begin
        seq_mis     = seq_valid_q && (fin_seq != exp_seq_q);
        good_d      = good_q;
        bad_d       = bad_q;
        seqe_d      = seqe_q;
        sticky_d    = sticky_q;
        exp_seq_d   = exp_seq_q;
        seq_valid_d = seq_valid_q;
        rdy_d       = 1'b1;
        if (chk_clr) begin
            good_d      = '0;
            bad_d       = '0;
            seqe_d      = '0;
            sticky_d    = 1'b0;
            seq_valid_d = 1'b0;
        end else if (fin) begin
            good_d   = fin_err ? good_q : good_q + CNT_WIDTH'(good_q != '1);
            bad_d    = fin_err ? bad_q + CNT_WIDTH'(bad_q != '1) : bad_q;
            seqe_d   = (fin_hdr && seq_mis) ? seqe_q + CNT_WIDTH'(seqe_q != '1) : seqe_q;
            sticky_d = sticky_q | fin_err | (fin_hdr & seq_mis);
            if (fin_hdr) begin
                exp_seq_d   = fin_seq + 32'd1;
                seq_valid_d = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= WAIT_SOF;
            beat_q      <= '0;
            err_q       <= 1'b0;
            hdr_ok_q    <= 1'b0;
            chk_q       <= 1'b0;
            seq_q       <= '0;
            exp_seq_q   <= '0;
            seq_valid_q <= 1'b0;
            good_q      <= '0;
            bad_q       <= '0;
            seqe_q      <= '0;
            sticky_q    <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            err_q       <= err_d;
            hdr_ok_q    <= hdr_ok_d;
            chk_q       <= chk_d;
            seq_q       <= seq_d;
            exp_seq_q   <= exp_seq_d;
            seq_valid_q <= seq_valid_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            seqe_q      <= seqe_d;
            sticky_q    <= sticky_d;
            rdy_q       <= rdy_d;
        end
    end
    assign good_frame_cnt = good_q;
    assign bad_frame_cnt  = bad_q;
    assign seq_err_cnt    = seqe_q;
    assign err_sticky     = sticky_q;
    assign chk_busy       = state_q != WAIT_SOF;
endmodule
